// File: rtl/riscv_pkg.sv
// Shared types and constants for the interrupt controller slice.
// Holds the controller FSM encoding and the mcause construction helper.
package riscv_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } irq_state_e;

    localparam int IRQ_CAUSE_BASE = 16;

    // Interrupt mcause: interrupt bit set, platform cause code offset by the base.
    function automatic logic [31:0] irq_cause(input logic [3:0] index);
        return {1'b1, 26'b0, 5'(IRQ_CAUSE_BASE + int'(index))};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
// Produces both the one-hot winner and its binary index.
module irq_prio_enc #(
    parameter int NUM_IRQ = 16
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [NUM_IRQ-1:0] onehot,
    output logic [3:0]         index,
    output logic               valid
);

    // Scan downward so the last hit, the lowest index, overrides higher ones.
    always_comb begin
        onehot = '0;
        index  = '0;
        valid  = |req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: level/edge pending logic, fixed-priority arbitration,
// and an IDLE/SERVICE handshake with the core (request, mret, acknowledge).
module irq_controller
    import riscv_pkg::*;
#(
    parameter int                 NUM_IRQ   = 16,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] mask_i,
    input  logic               gie_i,
    input  logic               irq_ret_i,
    output logic               irq_req_o,
    output logic [31:0]        irq_cause_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic               busy_o
);

    irq_state_e         state;
    irq_state_e         state_next;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] edge_latch;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] win_onehot;
    logic [3:0]         win_index;
    logic               win_valid;
    logic [NUM_IRQ-1:0] lat_onehot;
    logic [3:0]         lat_index;

    assign rise     = irq_i & ~irq_prev & EDGE_MASK;
    assign pending  = (irq_i & ~EDGE_MASK) | (edge_latch & EDGE_MASK);
    assign eligible = pending & mask_i & {NUM_IRQ{gie_i}};

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req    (eligible),
        .onehot (win_onehot),
        .index  (win_index),
        .valid  (win_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = SERVICE;
            SERVICE: if (irq_ret_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // History is reloaded during reset so a line already high is not seen as an edge.
    // A fresh rising edge beats the acknowledge-clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_prev   <= irq_i;
            edge_latch <= '0;
            lat_onehot <= '0;
            lat_index  <= '0;
        end else begin
            irq_prev   <= irq_i;
            edge_latch <= (edge_latch & ~irq_ack_o) | rise;
            if (state == IDLE && win_valid) begin
                lat_onehot <= win_onehot;
                lat_index  <= win_index;
            end
        end
    end

    assign irq_req_o   = (state == SERVICE);
    assign busy_o      = (state == SERVICE);
    assign irq_cause_o = (state == SERVICE) ? irq_cause(lat_index) : 32'h0;
    assign irq_ack_o   = (state == SERVICE && irq_ret_i && !rst_i) ? lat_onehot : '0;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller: channels 0 and 1 edge-sensitive, rest level.
module tb_irq_controller;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] irq_i;
    logic [15:0] mask_i;
    logic        gie_i;
    logic        irq_ret_i;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ack_o;
    logic        busy_o;

    int checks = 0;
    int passed = 0;

    irq_controller #(
        .NUM_IRQ   (16),
        .EDGE_MASK (16'h0003)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_i       (irq_i),
        .mask_i      (mask_i),
        .gie_i       (gie_i),
        .irq_ret_i   (irq_ret_i),
        .irq_req_o   (irq_req_o),
        .irq_cause_o (irq_cause_o),
        .irq_ack_o   (irq_ack_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_return();
        irq_ret_i = 1'b1;
        step();
        irq_ret_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; irq_i = '0; mask_i = 16'hFFFF; gie_i = 1'b1; irq_ret_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        #1;
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL reset_req got %b want 0", irq_req_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy_o); else passed++;
        checks++; if (irq_cause_o !== 32'h0) $display("[TB] FAIL reset_cause got %h want 0", irq_cause_o); else passed++;
        checks++; if (irq_ack_o !== 16'h0) $display("[TB] FAIL reset_ack got %h want 0", irq_ack_o); else passed++;
    endtask

    task automatic test_level();
        step();
        irq_i = 16'h0008;
        #1;
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL level_early got %b want 0", irq_req_o); else passed++;
        step();
        checks++; if (irq_req_o !== 1'b1) $display("[TB] FAIL level_req got %b want 1", irq_req_o); else passed++;
        checks++; if (irq_cause_o !== 32'h80000013) $display("[TB] FAIL level_cause got %h want 80000013", irq_cause_o); else passed++;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL level_busy got %b want 1", busy_o); else passed++;
        irq_i = 16'h000C; gie_i = 1'b0;
        step();
        checks++; if (irq_cause_o !== 32'h80000013) $display("[TB] FAIL level_frozen got %h want 80000013", irq_cause_o); else passed++;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL level_noabort got %b want 1", busy_o); else passed++;
        gie_i = 1'b1; irq_i = '0; irq_ret_i = 1'b1;
        #1;
        checks++; if (irq_ack_o !== 16'h0008) $display("[TB] FAIL level_ack got %h want 0008", irq_ack_o); else passed++;
        step();
        irq_ret_i = 1'b0;
        #1;
        checks++; if (irq_ack_o !== 16'h0) $display("[TB] FAIL level_ack_clear got %h want 0", irq_ack_o); else passed++;
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL level_req_drop got %b want 0", irq_req_o); else passed++;
    endtask

    task automatic test_priority();
        irq_i = 16'h0024;
        step();
        checks++; if (irq_cause_o !== 32'h80000012) $display("[TB] FAIL prio_first got %h want 80000012", irq_cause_o); else passed++;
        irq_i = 16'h0020; irq_ret_i = 1'b1;
        #1;
        checks++; if (irq_ack_o !== 16'h0004) $display("[TB] FAIL prio_ack got %h want 0004", irq_ack_o); else passed++;
        step();
        irq_ret_i = 1'b0;
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL prio_gap got %b want 0", irq_req_o); else passed++;
        step();
        checks++; if (irq_cause_o !== 32'h80000015) $display("[TB] FAIL prio_second got %h want 80000015", irq_cause_o); else passed++;
        irq_i = '0;
        do_return();
        step();
    endtask

    task automatic test_edge();
        irq_i = 16'h0001;
        step();
        irq_i = '0;
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL edge_latency got %b want 0", irq_req_o); else passed++;
        step();
        checks++; if (irq_cause_o !== 32'h80000010) $display("[TB] FAIL edge_cause got %h want 80000010", irq_cause_o); else passed++;
        step();
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL edge_hold got %b want 1", busy_o); else passed++;
        irq_i = 16'h0001; irq_ret_i = 1'b1;
        #1;
        checks++; if (irq_ack_o !== 16'h0001) $display("[TB] FAIL edge_ack got %h want 0001", irq_ack_o); else passed++;
        step();
        irq_i = '0; irq_ret_i = 1'b0;
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL edge_gap got %b want 0", irq_req_o); else passed++;
        step();
        checks++; if (irq_cause_o !== 32'h80000010) $display("[TB] FAIL edge_reservice got %h want 80000010", irq_cause_o); else passed++;
        do_return();
        step();
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL edge_cleared got %b want 0", irq_req_o); else passed++;
    endtask

    task automatic test_gating();
        irq_i = 16'h0080; mask_i = 16'hFF7F;
        step(); step();
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL gate_mask got %b want 0", irq_req_o); else passed++;
        mask_i = 16'hFFFF;
        step();
        checks++; if (irq_cause_o !== 32'h80000017) $display("[TB] FAIL gate_mask_en got %h want 80000017", irq_cause_o); else passed++;
        gie_i = 1'b0;
        do_return();
        step(); step();
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL gate_gie got %b want 0", irq_req_o); else passed++;
        gie_i = 1'b1;
        step();
        checks++; if (irq_req_o !== 1'b1) $display("[TB] FAIL gate_gie_en got %b want 1", irq_req_o); else passed++;
        irq_i = '0;
        do_return();
        step();
    endtask

    task automatic test_ret_idle();
        irq_ret_i = 1'b1;
        #1;
        checks++; if (irq_ack_o !== 16'h0) $display("[TB] FAIL ret_idle_ack got %h want 0", irq_ack_o); else passed++;
        step();
        irq_ret_i = 1'b0;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL ret_idle_state got %b want 0", busy_o); else passed++;
    endtask

    task automatic test_reset_in_service();
        irq_i = 16'h0010;
        step();
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL rst_svc_enter got %b want 1", busy_o); else passed++;
        rst_i = 1'b1; irq_i = '0;
        #1;
        checks++; if (irq_ack_o !== 16'h0) $display("[TB] FAIL rst_svc_ack got %h want 0", irq_ack_o); else passed++;
        step();
        rst_i = 1'b0;
        #1;
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL rst_svc_req got %b want 0", irq_req_o); else passed++;
        checks++; if (irq_cause_o !== 32'h0) $display("[TB] FAIL rst_svc_cause got %h want 0", irq_cause_o); else passed++;
        checks++; if (irq_ack_o !== 16'h0) $display("[TB] FAIL rst_svc_ack_after got %h want 0", irq_ack_o); else passed++;
    endtask

    task automatic test_reset_edge();
        rst_i = 1'b1; irq_i = 16'h0002;
        step(); step();
        rst_i = 1'b0;
        step(); step(); step();
        checks++; if (irq_req_o !== 1'b0) $display("[TB] FAIL rst_edge_req got %b want 0", irq_req_o); else passed++;
        irq_i = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_edge();
        test_gating();
        test_ret_idle();
        test_reset_in_service();
        test_reset_edge();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
